// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
// Digit widths, wrap limits, FSM states and blink encodings live here.
package stopwatch_pkg;

    localparam int TEN_W       = 3;
    localparam int ONE_W       = 4;
    localparam int DEF_MAX_TEN = 5;
    localparam int DEF_MAX_ONE = 9;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_e;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_SEC  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter 00..(MAX_TEN)(MAX_ONE); carryOut flags the increment that wraps to 00.
// Clear has priority over increment; both are synchronous.
module bcd_mod60_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_TEN = DEF_MAX_TEN,
    parameter int MAX_ONE = DEF_MAX_ONE
) (
    input  logic             clkDis,
    input  logic             rstN,
    input  logic             clr,
    input  logic             inc,
    output logic [TEN_W-1:0] tens,
    output logic [ONE_W-1:0] ones,
    output logic             carryOut
);

    localparam logic [TEN_W-1:0] TEN_TOP = TEN_W'(MAX_TEN);
    localparam logic [ONE_W-1:0] ONE_TOP = ONE_W'(MAX_ONE);

    logic [TEN_W-1:0] tens_q, tens_d;
    logic [ONE_W-1:0] ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc) begin
            if (ones_q == ONE_TOP) begin
                ones_d = '0;
                tens_d = (tens_q == TEN_TOP) ? '0 : tens_q + 1'b1;
            end else begin
                ones_d = ones_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clkDis) begin
        if (!rstN) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    // Suppressed by clear so a clear never ripples an increment into the next field.
    assign carryOut = inc && !clr && (ones_q == ONE_TOP) && (tens_q == TEN_TOP);
    assign tens     = tens_q;
    assign ones     = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: RUN/PAUSED/ADJUST FSM, switch synchronizers and
// increment steering into two mod-60 BCD counters (seconds, minutes).
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_TEN = DEF_MAX_TEN,
    parameter int MAX_ONE = DEF_MAX_ONE
) (
    input  logic             clkDis,
    input  logic             rstN,
    input  logic             clear,
    input  logic             pause,
    input  logic             tick1Hz,
    input  logic             tick2Hz,
    input  logic             adjSw,
    input  logic             selSw,
    output logic [TEN_W-1:0] m10,
    output logic [ONE_W-1:0] m1,
    output logic [TEN_W-1:0] s10,
    output logic [ONE_W-1:0] s1,
    output logic [1:0]       blinkSel
);

    logic   adj_meta_q, adj_q;
    logic   sel_meta_q, sel_q;
    state_e state_q, state_d;
    logic [1:0] blink_q, blink_d;

    logic sec_inc, min_inc, sec_carry, min_carry_unused;

    always_ff @(posedge clkDis) begin
        if (!rstN) begin
            adj_meta_q <= 1'b0;
            adj_q      <= 1'b0;
            sel_meta_q <= 1'b0;
            sel_q      <= 1'b0;
        end else begin
            adj_meta_q <= adjSw;
            adj_q      <= adj_meta_q;
            sel_meta_q <= selSw;
            sel_q      <= sel_meta_q;
        end
    end

    // Adjust dominates from any state; otherwise the pause level picks RUN/PAUSED.
    always_comb begin
        state_d = adj_q ? ST_ADJUST : (pause ? ST_PAUSED : ST_RUN);
        blink_d = BLINK_NONE;
        if (state_d == ST_ADJUST) begin
            blink_d = sel_q ? BLINK_SEC : BLINK_MIN;
        end
    end

    always_ff @(posedge clkDis) begin
        if (!rstN) begin
            state_q <= ST_RUN;
            blink_q <= BLINK_NONE;
        end else begin
            state_q <= state_d;
            blink_q <= blink_d;
        end
    end

    // The live pause level gates the 1 Hz tick so a tick coinciding with pause is dropped.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                sec_inc = tick1Hz && !pause;
                min_inc = sec_carry;
            end
            ST_ADJUST: begin
                sec_inc = tick2Hz && sel_q;
                min_inc = tick2Hz && !sel_q;
            end
            default: begin
                sec_inc = 1'b0;
                min_inc = 1'b0;
            end
        endcase
    end

    bcd_mod60_counter #(
        .MAX_TEN (MAX_TEN),
        .MAX_ONE (MAX_ONE)
    ) u_sec (
        .clkDis   (clkDis),
        .rstN     (rstN),
        .clr      (clear),
        .inc      (sec_inc),
        .tens     (s10),
        .ones     (s1),
        .carryOut (sec_carry)
    );

    bcd_mod60_counter #(
        .MAX_TEN (MAX_TEN),
        .MAX_ONE (MAX_ONE)
    ) u_min (
        .clkDis   (clkDis),
        .rstN     (rstN),
        .clr      (clear),
        .inc      (min_inc),
        .tens     (m10),
        .ones     (m1),
        .carryOut (min_carry_unused)
    );

    assign blinkSel = blink_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter: hand-computed MM:SS and blink expectations.
module tb_stopwatch_counter;

    logic       clkDis = 1'b0;
    logic       rstN = 1'b0, clear = 1'b0, pause = 1'b0;
    logic       tick1Hz = 1'b0, tick2Hz = 1'b0, adjSw = 1'b0, selSw = 1'b0;
    logic [2:0] m10, s10;
    logic [3:0] m1, s1;
    logic [1:0] blinkSel;
    logic [15:0] digits;

    int n_vec = 0;
    int n_bad = 0;

    stopwatch_counter dut (
        .clkDis   (clkDis),
        .rstN     (rstN),
        .clear    (clear),
        .pause    (pause),
        .tick1Hz  (tick1Hz),
        .tick2Hz  (tick2Hz),
        .adjSw    (adjSw),
        .selSw    (selSw),
        .m10      (m10),
        .m1       (m1),
        .s10      (s10),
        .s1       (s1),
        .blinkSel (blinkSel)
    );

    always #5 clkDis = ~clkDis;

    assign digits = {1'b0, m10, m1, 1'b0, s10, s1};

    function automatic logic [15:0] mmss(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clkDis);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_t1(input int n);
        tick1Hz = 1'b1;
        cyc(n);
        tick1Hz = 1'b0;
    endtask

    task automatic pulse_t2(input int n);
        tick2Hz = 1'b1;
        cyc(n);
        tick2Hz = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(2);
        chk("reset_digits", digits, mmss(0, 0));
        chk("reset_blink", 16'(blinkSel), 16'h0);
        rstN = 1'b1;

        // 60 seconds roll into one minute, no blink while running
        for (int i = 0; i < 60; i++) begin
            pulse_t1(1);
            chk("run_blink", 16'(blinkSel), 16'h0);
        end
        chk("run_60s", digits, mmss(1, 0));

        // Full-range wrap
        pulse_t1(3538);
        chk("preload_5958", digits, mmss(59, 58));
        pulse_t1(1);
        chk("wrap_5959", digits, mmss(59, 59));
        pulse_t1(1);
        chk("wrap_0000", digits, mmss(0, 0));

        // Pause raised together with a tick suppresses it, then 4 more ticks ignored
        pause = 1'b1;
        pulse_t1(5);
        chk("paused_hold", digits, mmss(0, 0));
        pause = 1'b0;
        cyc(1);
        pulse_t1(1);
        chk("resume_tick", digits, mmss(0, 1));

        // Adjust minutes from 00:58
        pulse_t1(57);
        chk("pre_adj", digits, mmss(0, 58));
        adjSw = 1'b1;
        selSw = 1'b0;
        cyc(2);
        chk("adj_lat2", 16'(blinkSel), 16'h0);
        cyc(1);
        chk("adj_lat3", 16'(blinkSel), 16'h2);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_t2(1);
            pulse_t1(1);
        end
        pause = 1'b0;
        chk("adj_min", digits, mmss(3, 58));
        chk("adj_min_blink", 16'(blinkSel), 16'h2);

        // Adjust seconds, wrap without carry
        selSw = 1'b1;
        cyc(2);
        chk("sel_lat2", 16'(blinkSel), 16'h2);
        cyc(1);
        chk("sel_lat3", 16'(blinkSel), 16'h1);
        pulse_t2(3);
        chk("adj_sec_nocarry", digits, mmss(3, 1));

        // Dial in 12:34
        pulse_t2(33);
        chk("adj_sec_34", digits, mmss(3, 34));
        selSw = 1'b0;
        cyc(3);
        chk("sel_back_min", 16'(blinkSel), 16'h2);
        pulse_t2(9);
        chk("adj_1234", digits, mmss(12, 34));
        adjSw = 1'b0;
        cyc(3);
        chk("exit_adj_blink", 16'(blinkSel), 16'h0);

        // Clear beats a coincident tick
        clear = 1'b1;
        tick1Hz = 1'b1;
        cyc(1);
        clear = 1'b0;
        tick1Hz = 1'b0;
        chk("clear_vs_tick", digits, mmss(0, 0));
        pulse_t1(3);
        chk("after_clear", digits, mmss(0, 3));

        // Clear while paused keeps PAUSED: the tick in the cycle pause drops is lost
        pause = 1'b1;
        cyc(1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clear_paused", digits, mmss(0, 0));
        pause = 1'b0;
        pulse_t1(1);
        chk("still_paused", digits, mmss(0, 0));
        pulse_t1(1);
        chk("resumed", digits, mmss(0, 1));

        // Reset during adjust at 07:07
        adjSw = 1'b1;
        selSw = 1'b0;
        cyc(3);
        chk("adj2_blink", 16'(blinkSel), 16'h2);
        pulse_t2(7);
        chk("adj2_min", digits, mmss(7, 1));
        selSw = 1'b1;
        cyc(3);
        pulse_t2(6);
        chk("adj2_0707", digits, mmss(7, 7));
        chk("adj2_sec_blink", 16'(blinkSel), 16'h1);
        rstN = 1'b0;
        cyc(1);
        rstN = 1'b1;
        chk("rst_adj_digits", digits, mmss(0, 0));
        chk("rst_adj_blink", 16'(blinkSel), 16'h0);
        cyc(2);
        chk("reenter_lat2", 16'(blinkSel), 16'h0);
        cyc(1);
        chk("reenter_lat3", 16'(blinkSel), 16'h1);
        pulse_t2(1);
        chk("reenter_inc", digits, mmss(0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
